// File: rtl/dab_ctrl_pkg.sv
// Shared fixed-point constants, FSM state and modulator-mode encodings for the DAB start-up sequencer.
package dab_ctrl_pkg;

    localparam int FX_W    = 38;
    localparam int FX_FRAC = 17;
    localparam int FX_WI   = FX_W + 1;

    localparam logic signed [FX_W-1:0] FX_ONE = 38'sd1 <<< FX_FRAC;
    localparam logic signed [FX_W-1:0] FX_MAX = {1'b0, {(FX_W-1){1'b1}}};
    localparam logic signed [FX_W-1:0] FX_MIN = {1'b1, {(FX_W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRECHARGE = 3'd1,
        ST_SYNC_WAIT = 3'd2,
        ST_RAMP      = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        MODO_IDLE  = 2'b00,
        MODO_START = 2'b01,
        MODO_RUN   = 2'b10,
        MODO_FAULT = 2'b11
    } modo_t;

    function automatic logic signed [FX_W-1:0] fx_sat(input logic signed [FX_WI-1:0] x);
        if (x > $signed({FX_MAX[FX_W-1], FX_MAX})) begin
            return FX_MAX;
        end else if (x < $signed({FX_MIN[FX_W-1], FX_MIN})) begin
            return FX_MIN;
        end
        return x[FX_W-1:0];
    endfunction

    // The modulator is phase-locked from SYNC_WAIT until shutdown completes.
    function automatic logic sync_of(input state_t s);
        return (s == ST_SYNC_WAIT) || (s == ST_RAMP) || (s == ST_RUN);
    endfunction

    function automatic modo_t modo_of(input state_t s);
        case (s)
            ST_SYNC_WAIT, ST_RAMP: return MODO_START;
            ST_RUN:                return MODO_RUN;
            ST_FAULT:              return MODO_FAULT;
            default:               return MODO_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/iref_ramp.sv
// Saturating rate limiter: moves value_o toward target_i by at most step_i per advance, never overshooting.
module iref_ramp
    import dab_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   zero_i,
    input  logic                   advance_i,
    input  logic signed [FX_W-1:0] target_i,
    input  logic signed [FX_W-1:0] step_i,
    output logic signed [FX_W-1:0] value_o
);

    logic signed [FX_W-1:0]  value_q, value_d;
    logic signed [FX_WI-1:0] value_w, target_w, step_w, diff_w, dist_w;

    assign value_w  = $signed({value_q[FX_W-1], value_q});
    assign target_w = $signed({target_i[FX_W-1], target_i});
    assign step_w   = $signed({step_i[FX_W-1], step_i});
    assign diff_w   = target_w - value_w;
    assign dist_w   = diff_w[FX_WI-1] ? -diff_w : diff_w;

    // A remaining distance within one step lands exactly on the target.
    always_comb begin
        value_d = value_q;
        if (zero_i) begin
            value_d = '0;
        end else if (advance_i) begin
            if (dist_w <= step_w) begin
                value_d = target_i;
            end else if (diff_w[FX_WI-1]) begin
                value_d = fx_sat(value_w - step_w);
            end else begin
                value_d = fx_sat(value_w + step_w);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/dab_startup_sequencer.sv
// DAB converter start-up sequencer: precharge, modulator sync, current ramp, run and shutdown.
// Overvoltage tripping into FAULT is built only when DAB_OVERVOLT_TRIP_EN is defined.
module dab_startup_sequencer
    import dab_ctrl_pkg::*;
#(
    parameter int unsigned             PRECHARGE_CYC = 1000,
    parameter logic signed [FX_W-1:0]  VDC1_MIN      = 38'sd39321600,
    parameter logic signed [FX_W-1:0]  VDC_MAX       = 38'sd52428800,
    parameter logic signed [FX_W-1:0]  RAMP_STEP     = 38'sd13107
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   CE,
    input  logic                   enable,
    input  logic signed [FX_W-1:0] Vdc1,
    input  logic signed [FX_W-1:0] Vdc2,
    input  logic signed [FX_W-1:0] iref_cmd,
    input  logic                   trigger,
    output logic                   sync,
    output logic signed [FX_W-1:0] iref_out,
    output logic [1:0]             modo_req,
    output logic                   fault,
    output logic [2:0]             state_o
);

    localparam logic [31:0] PC_LAST = (PRECHARGE_CYC > 0) ? 32'(PRECHARGE_CYC - 1) : 32'd0;

    state_t                 state_q, state_d;
    modo_t                  modo_q;
    logic                   sync_q;
    logic [31:0]            cnt_q, cnt_d;
    logic                   fault_cond;
    logic                   ramp_run, ramp_adv, ramp_zero;
    logic                   iref_zero, iref_at_cmd;
    logic signed [FX_W-1:0] ramp_target, iref_q;

`ifdef DAB_OVERVOLT_TRIP_EN
    logic fault_q;

    assign fault_cond = (state_q != ST_IDLE) && (state_q != ST_FAULT)
                        && ((Vdc1 > VDC_MAX) || (Vdc2 > VDC_MAX));
    assign fault = fault_q;
`else
    logic unused_ok;

    assign unused_ok  = ^{Vdc2, VDC_MAX};
    assign fault_cond = 1'b0;
    assign fault      = 1'b0;
`endif

    assign iref_zero   = (iref_q == '0);
    assign iref_at_cmd = (iref_q == iref_cmd);
    assign ramp_run    = (state_q == ST_RAMP) || (state_q == ST_RUN);

    // Dropping enable retargets the ramp to zero; the FSM leaves once zero is reached.
    assign ramp_target = enable ? iref_cmd : '0;
    assign ramp_adv    = CE && trigger && ramp_run && !fault_cond;
    assign ramp_zero   = CE && (fault_cond || (state_q == ST_FAULT) || (state_q == ST_IDLE));

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (fault_cond) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) state_d = ST_PRECHARGE;
                end
                ST_PRECHARGE: begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q;
                        if (cnt_q < PC_LAST) begin
                            cnt_d = cnt_q + 32'd1;
                        end else if (Vdc1 >= VDC1_MIN) begin
                            state_d = ST_SYNC_WAIT;
                        end
                    end
                end
                ST_SYNC_WAIT: begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (trigger) begin
                        state_d = ST_RAMP;
                    end
                end
                ST_RAMP: begin
                    if (!enable) begin
                        if (iref_zero) state_d = ST_IDLE;
                    end else if (iref_at_cmd) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!enable && iref_zero) state_d = ST_IDLE;
                end
                ST_FAULT: begin
                    if (!enable) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Mode and sync are decoded from the next state so they change on the same edge as state_o.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sync_q  <= 1'b0;
            modo_q  <= MODO_IDLE;
`ifdef DAB_OVERVOLT_TRIP_EN
            fault_q <= 1'b0;
`endif
        end else if (CE) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync_q  <= sync_of(state_d);
            modo_q  <= modo_of(state_d);
`ifdef DAB_OVERVOLT_TRIP_EN
            fault_q <= (state_d == ST_FAULT);
`endif
        end
    end

    iref_ramp u_iref_ramp (
        .clk       (clk),
        .rst_n     (rst),
        .zero_i    (ramp_zero),
        .advance_i (ramp_adv),
        .target_i  (ramp_target),
        .step_i    (RAMP_STEP),
        .value_o   (iref_q)
    );

    assign sync     = sync_q;
    assign iref_out = iref_q;
    assign modo_req = modo_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_dab_startup_sequencer.sv
// Directed bench for dab_startup_sequencer: precharge hold, sync, ramp up/down, overvoltage and async reset.
module tb_dab_startup_sequencer;
    import dab_ctrl_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   CE;
    logic                   enable;
    logic signed [FX_W-1:0] Vdc1;
    logic signed [FX_W-1:0] Vdc2;
    logic signed [FX_W-1:0] iref_cmd;
    logic                   trigger;
    logic                   sync;
    logic signed [FX_W-1:0] iref_out;
    logic [1:0]             modo_req;
    logic                   fault;
    logic [2:0]             state_o;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dab_startup_sequencer #(
        .PRECHARGE_CYC (1000),
        .VDC1_MIN      (38'sd39321600),
        .VDC_MAX       (38'sd52428800),
        .RAMP_STEP     (38'sd13107)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .CE       (CE),
        .enable   (enable),
        .Vdc1     (Vdc1),
        .Vdc2     (Vdc2),
        .iref_cmd (iref_cmd),
        .trigger  (trigger),
        .sync     (sync),
        .iref_out (iref_out),
        .modo_req (modo_req),
        .fault    (fault),
        .state_o  (state_o)
    );

    task automatic chk(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse();
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        CE       = 1'b1;
        enable   = 1'b0;
        trigger  = 1'b0;
        Vdc1     = 340 * FX_ONE;
        Vdc2     = 380 * FX_ONE;
        iref_cmd = 38'sd2621440;
        #2;
        chk("rst_state", state_o, 0);
        chk("rst_sync", sync, 0);
        chk("rst_iref", iref_out, 0);
        chk("rst_modo", modo_req, 0);
        chk("rst_fault", fault, 0);
        tick(2);
        rst = 1'b1;
        tick(2);
        chk("idle_hold", state_o, 0);

        CE = 1'b0;
        enable = 1'b1;
        tick(3);
        chk("ce_freeze_idle", state_o, 0);
        CE = 1'b1;
        tick(1);
        chk("pre_entry", state_o, 1);
        chk("pre_modo", modo_req, 0);

        tick(500);
        CE = 1'b0;
        tick(10);
        CE = 1'b1;
        tick(499);
        chk("pre_last_cycle", state_o, 1);
        tick(1);
        chk("sync_wait_state", state_o, 2);
        chk("sync_wait_sync", sync, 1);
        chk("sync_wait_modo", modo_req, 1);
        tick(5);
        chk("sync_wait_hold", state_o, 2);

        pulse();
        chk("ramp_entry", state_o, 3);
        chk("ramp_entry_iref", iref_out, 0);
        tick(2);
        pulse();
        chk("ramp_step1", iref_out, 13107);
        CE = 1'b0;
        pulse();
        chk("ramp_ce_freeze", iref_out, 13107);
        CE = 1'b1;
        for (int i = 0; i < 199; i++) begin
            tick(2);
            pulse();
        end
        chk("ramp_200", iref_out, 2621400);
        chk("ramp_200_state", state_o, 3);
        tick(2);
        pulse();
        chk("ramp_201_exact", iref_out, 2621440);
        chk("ramp_201_state", state_o, 3);
        tick(1);
        chk("run_state", state_o, 4);
        chk("run_modo", modo_req, 2);
        chk("run_sync", sync, 1);

        iref_cmd = -38'sd1310720;
        tick(1);
        pulse();
        chk("run_down1", iref_out, 2608333);
        for (int i = 0; i < 299; i++) begin
            tick(1);
            pulse();
        end
        chk("run_down300", iref_out, -1310660);
        tick(1);
        pulse();
        chk("run_down_exact", iref_out, -1310720);
        tick(1);
        pulse();
        chk("run_no_undershoot", iref_out, -1310720);
        chk("run_still", state_o, 4);

        Vdc2 = 410 * FX_ONE;
        tick(1);
`ifdef DAB_OVERVOLT_TRIP_EN
        chk("ov_state", state_o, 5);
        chk("ov_iref", iref_out, 0);
        chk("ov_fault", fault, 1);
        chk("ov_modo", modo_req, 3);
        chk("ov_sync", sync, 0);
        Vdc2 = 380 * FX_ONE;
        tick(2);
        chk("fault_hold", state_o, 5);
        enable = 1'b0;
        tick(1);
        chk("fault_exit_state", state_o, 0);
        chk("fault_exit_flag", fault, 0);
`else
        chk("no_ov_state", state_o, 4);
        chk("no_ov_fault", fault, 0);
        chk("no_ov_iref", iref_out, -1310720);
        Vdc2 = 380 * FX_ONE;
        enable = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            pulse();
        end
        chk("shut_100", iref_out, -20);
        tick(1);
        pulse();
        chk("shut_zero", iref_out, 0);
        chk("shut_zero_state", state_o, 4);
        tick(1);
        chk("shut_idle", state_o, 0);
        chk("shut_sync", sync, 0);
        chk("shut_modo", modo_req, 0);
`endif

        Vdc1 = 250 * FX_ONE;
        enable = 1'b1;
        tick(1);
        chk("lowv_pre", state_o, 1);
        tick(1020);
        chk("lowv_hold", state_o, 1);
        Vdc1 = 340 * FX_ONE;
        tick(1);
        chk("lowv_release", state_o, 2);
        enable = 1'b0;
        tick(1);
        chk("sync_wait_abort", state_o, 0);

        iref_cmd = 38'sd2621440;
        enable = 1'b1;
        tick(1);
        tick(1000);
        chk("pre2_done", state_o, 2);
        pulse();
        for (int i = 0; i < 50; i++) begin
            tick(1);
            pulse();
        end
        chk("ramp5a", iref_out, 655350);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_iref", iref_out, 0);
        chk("async_rst_state", state_o, 0);
        chk("async_rst_sync", sync, 0);
        chk("async_rst_modo", modo_req, 0);
        tick(1);
        rst = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
